// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the trace capture unit: FSM state encodings, the
// width of the cycle stamp, and a saturating stamp increment helper.
// -----------------------------------------------------------------------------
package trace_pkg;

   localparam int STAMP_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DUMP    = 2'd3
   } trace_state_e;

   // Stamps stop at all-ones rather than wrapping, so a long capture never
   // reports a small (misleading) spacing.
   function automatic logic [STAMP_W-1:0] stamp_inc(input logic [STAMP_W-1:0] s);
      return (s == '1) ? s : s + STAMP_W'(1);
   endfunction

endpackage

// File: rtl/trace_capture_if.sv
// -----------------------------------------------------------------------------
// trace_capture_if
// Read-out port of the trace capture unit.
//   rd_valid  : entry presented (producer -> consumer)
//   rd_ready  : consumer accepts entry (consumer -> producer)
//   rd_pc     : entry PC
//   rd_data   : entry channel values, channel k at [k*DATA_W +: DATA_W]
//   rd_stamp  : clocks since the trigger sample
// Handshake: an entry transfers on every rising clock edge where
// rd_valid && rd_ready. While rd_valid is high and rd_ready is low the producer
// holds rd_pc/rd_data/rd_stamp stable; rd_valid never depends on rd_ready.
// Modports: master = producer (trace_capture), slave = consumer.
// -----------------------------------------------------------------------------
interface trace_capture_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4
) ();
   import trace_pkg::*;

   logic                     rd_valid;
   logic                     rd_ready;
   logic [ADDR_W-1:0]        rd_pc;
   logic [NUM_CH*DATA_W-1:0] rd_data;
   logic [STAMP_W-1:0]       rd_stamp;

   modport master (
      output rd_valid, rd_pc, rd_data, rd_stamp,
      input  rd_ready
   );

   modport slave (
      input  rd_valid, rd_pc, rd_data, rd_stamp,
      output rd_ready
   );

endinterface

// File: rtl/trace_buffer_ram.sv
// -----------------------------------------------------------------------------
// trace_buffer_ram
// DEPTH x WIDTH register array holding captured trace entries.
// One synchronous write port, one asynchronous read port, no reset (contents
// are only meaningful after a capture has written them).
//   clock : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module trace_buffer_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32,
   parameter int PTR_W = 4
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_capture.sv
// -----------------------------------------------------------------------------
// trace_capture
// On-chip trace unit for the pipelined core. When armed it waits for a PC
// trigger, records DEPTH samples of PC plus NUM_CH watched registers with a
// cycle stamp, then streams them out oldest first.
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   arm        : start request, honoured only in IDLE
//   abort      : return to IDLE from any state (highest priority)
//   trig_pc    : trigger address, compared while ARMED
//   sample_en  : pipeline advanced this cycle
//   pc         : current PC
//   ch_data    : watched registers, channel k at [k*DATA_W +: DATA_W]
//   rd         : read-out port (trace_capture_if.master)
//   state      : FSM state, IDLE=0 ARMED=1 CAPTURE=2 DUMP=3
// Build option: TRACE_CHANGE_ONLY_EN -- when defined, CAPTURE records a sample
// only if (pc, ch_data) differs from the last recorded entry.
// -----------------------------------------------------------------------------
module trace_capture
   import trace_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [ADDR_W-1:0]        trig_pc,
   input  logic                     sample_en,
   input  logic [ADDR_W-1:0]        pc,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   trace_capture_if.master          rd,
   output logic [1:0]               state
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CH_W    = NUM_CH * DATA_W;
   localparam int ENTRY_W = ADDR_W + CH_W + STAMP_W;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   trace_state_e       state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [STAMP_W-1:0] stamp_q, stamp_d;

   logic               trig_hit;
   logic               sample_new;
   logic               wr_en;
   logic [STAMP_W-1:0] wr_stamp;
   logic               dump_valid;
   logic               rd_fire;
   logic               last_wr;
   logic               last_rd;
   logic               arm_enter;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;

   assign trig_hit  = (state_q == ST_ARMED) && sample_en && (pc == trig_pc);
   assign last_wr   = wr_en && (wr_ptr_q == LAST_PTR);
   assign rd_fire   = dump_valid && rd.rd_ready;
   assign last_rd   = rd_fire && (rd_ptr_q == LAST_PTR);
   assign arm_enter = (state_q == ST_IDLE) && arm && !abort;

`ifdef TRACE_CHANGE_ONLY_EN
   // Last recorded sample; the trigger write seeds it.
   logic [ADDR_W-1:0] shadow_pc_q;
   logic [CH_W-1:0]   shadow_data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_pc_q   <= '0;
         shadow_data_q <= '0;
      end else if (wr_en) begin
         shadow_pc_q   <= pc;
         shadow_data_q <= ch_data;
      end
   end

   assign sample_new = (pc != shadow_pc_q) || (ch_data != shadow_data_q);
`else
   assign sample_new = 1'b1;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:    if (arm)      state_d = ST_ARMED;
            // With DEPTH=1 the trigger write is also the last write.
            ST_ARMED:   if (trig_hit) state_d = last_wr ? ST_DUMP : ST_CAPTURE;
            ST_CAPTURE: if (last_wr)  state_d = ST_DUMP;
            ST_DUMP:    if (last_rd)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      wr_en      = 1'b0;
      wr_stamp   = '0;
      dump_valid = 1'b0;
      unique case (state_q)
         ST_ARMED: begin
            wr_en    = trig_hit;
            wr_stamp = '0;
         end
         ST_CAPTURE: begin
            wr_en    = sample_en && sample_new;
            // stamp_q holds the stamp of the previous clock; this clock is one later.
            wr_stamp = stamp_inc(stamp_q);
         end
         ST_DUMP: begin
            dump_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------- pointers and stamp ----------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      stamp_d  = stamp_q;
      if (arm_enter) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Stamp advances on every CAPTURE clock, stalled or not.
      if (trig_hit) begin
         stamp_d = '0;
      end else if (state_q == ST_CAPTURE) begin
         stamp_d = stamp_inc(stamp_q);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         stamp_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         stamp_q  <= stamp_d;
      end
   end

   // ---------------- buffer ----------------
   assign wr_entry = {pc, ch_data, wr_stamp};

   trace_buffer_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W)
   ) u_ram (
      .clock (clock),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   // Fields are forced to zero outside DUMP so reset and idle show clean zeros
   // regardless of the unreset buffer contents.
   assign rd.rd_valid = dump_valid;
   assign rd.rd_pc    = dump_valid ? rd_entry[ENTRY_W-1 -: ADDR_W]  : '0;
   assign rd.rd_data  = dump_valid ? rd_entry[STAMP_W +: CH_W]      : '0;
   assign rd.rd_stamp = dump_valid ? rd_entry[STAMP_W-1:0]          : '0;
   assign state       = state_q;

endmodule

// File: doc/trace_capture.md
# trace_capture

Synthesizable trace unit for the pipelined MIPS core. It replaces per-cycle textual dumps of the PC and selected registers with an on-chip circular capture. When armed, it waits for a programmable PC trigger and records DEPTH samples of PC plus NUM_CH watched register values, each with a cycle stamp. It then streams the samples out, oldest first, over a valid/ready port. It sits beside the pipeline, fed from the PC register and register-file taps.

## Interface
- ADDR_W, 32, PC width
- DATA_W, 32, width of one watched register
- NUM_CH, 4, number of watched registers (1..8)
- DEPTH, 16, entries captured after trigger; power of two, 2..256
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle start request; honoured only in IDLE
- abort  in  1  return to IDLE from any state, dropping the capture
- trig_pc  in  ADDR_W  trigger address; sampled every cycle while ARMED
- sample_en  in  1  pipeline advanced this cycle (not stalled)
- pc  in  ADDR_W  current PC
- ch_data  in  NUM_CH*DATA_W  watched registers; channel k at bits [k*DATA_W +: DATA_W]
- rd_valid  out  1  output entry valid
- rd_ready  in  1  consumer accepts entry
- rd_pc  out  ADDR_W  entry PC
- rd_data  out  NUM_CH*DATA_W  entry channel values
- rd_stamp  out  16  clocks since the trigger sample
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DUMP=3

## Operation
- IDLE: no writes, rd_valid=0. arm -> ARMED.
- ARMED: the first cycle with sample_en=1 and pc==trig_pc is the trigger. It writes entry 0 with stamp 0 and moves to CAPTURE.
- CAPTURE: writes one entry per qualifying cycle (see Configuration) at wr_ptr, which then increments. On the write of entry DEPTH-1 -> DUMP.
- DUMP: rd_valid=1. An entry is presented at rd_ptr, starting at 0. On rd_valid&&rd_ready, rd_ptr increments. Acceptance of entry DEPTH-1 -> IDLE.
- Stamp counter: cleared to 0 at the trigger and incremented every clock in CAPTURE, including stalled cycles. It saturates at 16'hFFFF and never wraps.
- Pointers are log2(DEPTH) bits and are cleared on entry to ARMED. No wrap-around occurs within one capture, because capture stops at DEPTH.
- abort has priority over every transition. On abort: state=IDLE, rd_valid=0 next cycle, and buffer contents become don't-care.
- arm outside IDLE is ignored. arm and abort in the same cycle -> IDLE.
- DEPTH=1: the trigger write goes directly to DUMP.

## Timing
- Reset (async, reset_n=0): state=IDLE, rd_valid=0, rd_pc=0, rd_data=0, rd_stamp=0. Pointers and stamp counter are 0.
- Reset mid-capture or mid-dump: immediate return to the reset values; no partial dump resumes.
- arm in cycle N -> state=ARMED in cycle N+1. A trigger match is first evaluated in N+1, even if pc==trig_pc in N.
- Trigger at edge T -> entry 0 written at T; state=CAPTURE from T+1.
- The DUMP state is registered. Buffer read is asynchronous from the registered rd_ptr, so rd_valid and rd_pc/rd_data/rd_stamp are valid in the first DUMP cycle.
- Output fields are held stable while rd_valid&&!rd_ready. With rd_ready held high, one entry is transferred per clock: DEPTH entries in DEPTH cycles.
- Last write -> rd_valid=1 on the next cycle. Last acceptance -> state=IDLE and rd_valid=0 on the next cycle.

## Configuration
- TRACE_CHANGE_ONLY_EN defined: in CAPTURE, a sample is written only if sample_en=1 and (pc, ch_data) differs from the last written entry. The trigger sample is always written. A shadow register holds the last written pc/ch_data. rd_stamp then gives the true spacing between recorded events.
- Undefined: every sample_en=1 cycle in CAPTURE is written, and no shadow register exists.

## Structure
- Shared package trace_pkg holds the state encodings (ST_IDLE..ST_DUMP) and STAMP_W=16.
- Sub-module trace_buffer_ram is a DEPTH x (ADDR_W+NUM_CH*DATA_W+16) register array with one synchronous write port and one asynchronous read port. It has no reset.
- The top holds the FSM, pointers, stamp counter, trigger compare and the optional change filter.

## Test plan
- Basic, DEPTH=4, NUM_CH=2: arm, trig_pc=0x0000_0010, then PC stepping by 4 with sample_en=1 -> 4 entries read with PC 0x10,0x14,0x18,0x1C and stamps 0,1,2,3. state=IDLE after the 4th handshake.
- Stalls: sample_en=0 for 2 cycles after the trigger -> entry 1 has stamp 3. No entry is written during the stall.
- Backpressure: rd_ready toggles 1,0,0,1 -> rd_pc/rd_data/rd_stamp are unchanged across the low cycles; no entry is lost or duplicated.
- Events: arm in the same cycle as pc==trig_pc -> no trigger that cycle; trigger fires at the next match. abort in DUMP after 1 entry -> rd_valid=0 and state=IDLE next cycle.
- Reset: reset_n=0 asserted mid-CAPTURE between clock edges -> outputs are 0 and state=IDLE immediately. After release, a full arm/trigger/dump sequence works.
- TRACE_CHANGE_ONLY_EN: hold pc/ch_data constant for 5 sample cycles after the trigger, then change ch_data[0] to 0x1234_5678 -> entry 1 holds 0x1234_5678 with stamp 6.
